// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one uart_tx register port among N_REQ byte requesters; init writes BAUD then CTRL.
// Ready pulses in CHECK (>=3 cycles from IDLE); requesters hold valid until ready; grants wait for STATUS[0]=0 and enable_i.
module uart_tx_sched #(
  parameter int          N_REQ     = 2,
  parameter logic [31:0] BAUD_DIV  = 32'h1B8,
  parameter int          MAX_RETRY = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid_i,
  input  logic [8*N_REQ-1:0]   req_data_i,
  output logic [N_REQ-1:0]     req_ready_o,
  input  logic                 enable_i,
  output logic                 uart_req_o,
  output logic                 uart_we_o,
  output logic [31:0]          uart_addr_o,
  output logic [31:0]          uart_data_o,
  input  logic [31:0]          uart_data_i,
  output logic                 busy_o,
  output logic [2:0]           grant_id_o,
  output logic                 err_o
);

  typedef enum logic [2:0] {INIT_BAUD, INIT_CTRL, IDLE, WRITE, CHECK} state_t;

  state_t      state_q, state_d;
  logic [2:0]  last_q, last_d;
  logic [2:0]  grant_q, grant_d;
  logic [7:0]  byte_q, byte_d;
  logic [7:0]  retry_q, retry_d;
  logic        err_q, err_d;

  logic        hi_hit, lo_hit, rr_hit;
  logic [2:0]  hi_idx, lo_idx, rr_idx;
  logic [7:0]  rr_byte;
  logic        done;
  logic        we_c;
  logic [31:0] addr_c, data_c;

  // Only STATUS[0] carries meaning for this master.
  logic unused_rdata;
  assign unused_rdata = ^uart_data_i[31:1];

  // Round-robin: first valid index above last grant, else first valid index from 0.
  always_comb begin
    hi_hit  = 1'b0;
    lo_hit  = 1'b0;
    hi_idx  = 3'd0;
    lo_idx  = 3'd0;
    rr_byte = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (!hi_hit && req_valid_i[i] && (3'(i) > last_q)) begin
        hi_hit = 1'b1;
        hi_idx = 3'(i);
      end
      if (!lo_hit && req_valid_i[i]) begin
        lo_hit = 1'b1;
        lo_idx = 3'(i);
      end
    end
    rr_hit = hi_hit | lo_hit;
    rr_idx = hi_hit ? hi_idx : lo_idx;
    for (int i = 0; i < N_REQ; i++) begin
      if (rr_idx == 3'(i)) rr_byte = req_data_i[8*i +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    byte_d  = byte_q;
    retry_d = retry_q;
    err_d   = err_q;
    done    = 1'b0;
    we_c    = 1'b0;
    addr_c  = 32'h4;
    data_c  = 32'h0;
    busy_o  = 1'b1;
    case (state_q)
      INIT_BAUD: begin
        we_c    = 1'b1;
        addr_c  = 32'h8;
        data_c  = BAUD_DIV;
        state_d = INIT_CTRL;
      end
      INIT_CTRL: begin
        we_c    = 1'b1;
        addr_c  = 32'h0;
        data_c  = 32'h1;
        state_d = IDLE;
      end
      IDLE: begin
        busy_o = 1'b0;
        if (enable_i && !uart_data_i[0] && rr_hit) begin
          state_d = WRITE;
          grant_d = rr_idx;
          byte_d  = rr_byte;
          retry_d = 8'd0;
        end
      end
      WRITE: begin
        we_c    = 1'b1;
        addr_c  = 32'hC;
        data_c  = {24'h0, byte_q};
        state_d = CHECK;
      end
      CHECK: begin
        if (uart_data_i[0]) begin
          done    = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end else if ((int'(retry_q) + 1) < MAX_RETRY) begin
          retry_d = retry_q + 8'd1;
          state_d = WRITE;
        end else begin
          err_d   = 1'b1;
          done    = 1'b1;
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = INIT_BAUD;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready_o[i] = done && (grant_q == 3'(i));
    end
  end

  // The bus is held quiet for as long as reset is asserted.
  assign uart_req_o  = rst;
  assign uart_we_o   = rst & we_c;
  assign uart_addr_o = rst ? addr_c : 32'h0;
  assign uart_data_o = rst ? data_c : 32'h0;
  assign grant_id_o  = grant_q;
  assign err_o       = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= INIT_BAUD;
      last_q  <= 3'(N_REQ - 1);
      grant_q <= 3'd0;
      byte_q  <= 8'h00;
      retry_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      byte_q  <= byte_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: behavioural uart_tx register model plus a round-robin scoreboard.
module tb_uart_tx_sched;
  localparam int          N    = 2;
  localparam logic [31:0] BAUD = 32'd4;
  localparam int          MAXR = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid_i;
  logic [8*N-1:0] req_data_i;
  logic [N-1:0]  req_ready_o;
  logic          enable_i;
  logic          uart_req_o, uart_we_o;
  logic [31:0]   uart_addr_o, uart_data_o, uart_data_i;
  logic          busy_o;
  logic [2:0]    grant_id_o;
  logic          err_o;

  uart_tx_sched #(.N_REQ(N), .BAUD_DIV(BAUD), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .enable_i(enable_i),
    .uart_req_o(uart_req_o), .uart_we_o(uart_we_o), .uart_addr_o(uart_addr_o),
    .uart_data_o(uart_data_o), .uart_data_i(uart_data_i),
    .busy_o(busy_o), .grant_id_o(grant_id_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  // uart_tx register model: a frame keeps STATUS[0] high for 10 bit times.
  logic [31:0] m_ctrl = 32'h0;
  logic [31:0] m_baud = 32'h0;
  int          m_busy_cnt = 0;
  logic        m_acc = 1'b0;
  logic [7:0]  m_last_byte = 8'h00;
  int          n_wr = 0;
  int          viol = 0;
  logic        force_drop = 1'b0;

  always_comb uart_data_i = (uart_addr_o == 32'h4) ? {31'b0, m_busy_cnt != 0} : 32'h0;

  always @(posedge clk) begin
    if (m_busy_cnt != 0) m_busy_cnt <= m_busy_cnt - 1;
    if (uart_req_o && uart_we_o) begin
      if (uart_addr_o == 32'h0) m_ctrl <= uart_data_o;
      else if (uart_addr_o == 32'h8) m_baud <= uart_data_o;
      else if (uart_addr_o == 32'hC) begin
        n_wr <= n_wr + 1;
        if (m_busy_cnt != 0) viol <= viol + 1;
        if (m_ctrl[0] && !force_drop && m_busy_cnt == 0) begin
          m_busy_cnt  <= 10 * int'(m_baud);
          m_acc       <= 1'b1;
          m_last_byte <= uart_data_o[7:0];
        end else begin
          m_acc <= 1'b0;
        end
      end
    end
  end

  int total = 0;
  int bad   = 0;

  // Requester side and scoreboard state.
  logic [N-1:0] pend;
  logic [7:0]   cur [N];
  int           rdy_cnt [N];
  int           rdy_done [N];
  int           refill_mode;
  logic         scramble_en;
  logic         in_xfer, prev_wc, m_err;
  int           exp_id, attempts, m_last;
  logic [7:0]   exp_byte;
  logic [N-1:0] prev_mask;
  logic [7:0]   pdat [N];
  int           order_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr(input logic [N-1:0] mask, input int last);
    int r;
    r = -1;
    for (int k = 1; k <= N; k++) begin
      if (r < 0 && mask[(last + k) % N]) r = (last + k) % N;
    end
    return r;
  endfunction

  task automatic snap();
    prev_mask = req_valid_i;
    for (int i = 0; i < N; i++) pdat[i] = req_data_i[8*i +: 8];
  endtask

  task automatic check_cycle();
    logic wc, fin;
    logic [N-1:0] e, one;
    one = 1;
    if (!rst) begin
      in_xfer = 1'b0;
      prev_wc = 1'b0;
      m_last  = N - 1;
      m_err   = 1'b0;
    end else begin
      chk("err_o", err_o, m_err);
      wc = uart_req_o && uart_we_o && (uart_addr_o == 32'hC);
      if (prev_wc) begin
        chk("check_we_low", uart_we_o, 0);
        fin = m_acc || (attempts >= MAXR);
        e = fin ? (one << exp_id) : '0;
        chk("ready_check", req_ready_o, e);
        if (fin) begin
          if (!m_acc) m_err = 1'b1;
          m_last  = exp_id;
          in_xfer = 1'b0;
        end
      end else begin
        chk("ready_quiet", req_ready_o, 0);
      end
      for (int i = 0; i < N; i++) begin
        if (req_ready_o[i]) begin
          rdy_cnt[i]++;
          order_q.push_back(i);
        end
      end
      if (wc) begin
        if (!in_xfer) begin
          exp_id   = rr(prev_mask, m_last);
          exp_byte = (exp_id >= 0) ? pdat[exp_id] : 8'h00;
          attempts = 0;
          in_xfer  = 1'b1;
          chk("grant_id", grant_id_o, exp_id);
        end
        attempts++;
        chk("txdata", uart_data_o, {24'h0, exp_byte});
      end
      prev_wc = wc;
    end
    snap();
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid_i[i] = pend[i];
      req_data_i[8*i +: 8] = (scramble_en && in_xfer && exp_id == i) ? 8'($urandom) : cur[i];
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (rdy_cnt[i] != rdy_done[i]) begin
        rdy_done[i] = rdy_cnt[i];
        pend[i] = (refill_mode == 1);
      end
      if (!pend[i] && refill_mode == 2 && $urandom_range(0, 3) == 0) begin
        pend[i] = 1'b1;
        cur[i]  = 8'($urandom);
      end
    end
    apply();
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (pend != '0 && n < 2000) begin
      step();
      n++;
    end
    chk(tag, pend, 0);
  endtask

  task automatic check_init(input string tag);
    chk({tag, "_baud_we"},   uart_we_o, 1);
    chk({tag, "_baud_addr"}, uart_addr_o, 32'h8);
    chk({tag, "_baud_data"}, uart_data_o, BAUD);
    chk({tag, "_baud_req"},  uart_req_o, 1);
    step();
    chk({tag, "_ctrl_we"},   uart_we_o, 1);
    chk({tag, "_ctrl_addr"}, uart_addr_o, 32'h0);
    chk({tag, "_ctrl_data"}, uart_data_o, 32'h1);
    step();
    chk({tag, "_idle_we"},   uart_we_o, 0);
    chk({tag, "_idle_addr"}, uart_addr_o, 32'h4);
    chk({tag, "_idle_busy"}, busy_o, 0);
  endtask

  initial begin
    int cnt, start, w0, b0, b1;
    rst = 1'b0; enable_i = 1'b0; req_valid_i = '0; req_data_i = '0;
    pend = '0; refill_mode = 0; scramble_en = 1'b0;
    in_xfer = 1'b0; prev_wc = 1'b0; m_err = 1'b0; m_last = N - 1;
    exp_id = 0; attempts = 0; exp_byte = 8'h00; prev_mask = '0;
    for (int i = 0; i < N; i++) begin
      cur[i] = 8'h00; rdy_cnt[i] = 0; rdy_done[i] = 0; pdat[i] = 8'h00;
    end

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_uart_req", uart_req_o, 0);
    chk("rst_we",       uart_we_o, 0);
    chk("rst_addr",     uart_addr_o, 0);
    chk("rst_data",     uart_data_o, 0);
    chk("rst_ready",    req_ready_o, 0);
    chk("rst_err",      err_o, 0);
    chk("rst_grant",    grant_id_o, 0);
    chk("rst_busy",     busy_o, 1);
    rst = 1'b1;
    #1;
    check_init("init");

    // Single byte from requester 0, minimum latency.
    enable_i = 1'b1;
    pend[0] = 1'b1; cur[0] = 8'hA5; apply();
    cnt = 0; start = rdy_cnt[0];
    while (rdy_cnt[0] == start && cnt < 20) begin step(); cnt++; end
    chk("single_latency", cnt, 3);
    chk("single_byte", m_last_byte, 8'hA5);

    // Fairness: both held valid, last grant was 0 so order is 1,0,1,0.
    refill_mode = 1;
    pend = '1; cur[0] = 8'h11; cur[1] = 8'h22; apply();
    order_q.delete();
    cnt = 0;
    while (order_q.size() < 4 && cnt < 800) begin step(); cnt++; end
    chk("fair_count", order_q.size() >= 4, 1);
    for (int k = 0; k < 4; k++) chk("fair_order", order_q[k], (k % 2 == 0) ? 1 : 0);
    refill_mode = 0;
    drain("fair_drain");

    // enable_i=0 blocks new grants.
    enable_i = 1'b0;
    pend[1] = 1'b1; cur[1] = 8'h5A; apply();
    w0 = n_wr;
    repeat (60) step();
    chk("en_block_writes", n_wr - w0, 0);
    chk("en_block_busy", busy_o, 0);
    enable_i = 1'b1;
    step();
    chk("en_grant_we",   uart_we_o, 1);
    chk("en_grant_addr", uart_addr_o, 32'hC);
    chk("en_grant_id",   grant_id_o, 1);
    chk("en_grant_busy", busy_o, 1);
    drain("en_drain");

    // Random traffic with data scrambled during transfers.
    b0 = rdy_cnt[0] + rdy_cnt[1];
    refill_mode = 2; scramble_en = 1'b1;
    for (int t = 0; t < 1500; t++) begin
      enable_i = ($urandom_range(0, 7) != 0);
      step();
    end
    refill_mode = 0; enable_i = 1'b1;
    drain("rand_drain");
    scramble_en = 1'b0;
    b1 = rdy_cnt[0] + rdy_cnt[1];
    chk("rand_progress", (b1 - b0) > 10, 1);

    // Dropped writes: MAX_RETRY attempts, one ready pulse, sticky error.
    force_drop = 1'b1;
    w0 = n_wr;
    pend[0] = 1'b1; cur[0] = 8'h3C; apply();
    cnt = 0; start = rdy_cnt[0];
    while (rdy_cnt[0] == start && cnt < 60) begin step(); cnt++; end
    chk("drop_ready_seen", rdy_cnt[0] - start, 1);
    chk("drop_writes", n_wr - w0, MAXR);
    chk("drop_err", err_o, 1);
    force_drop = 1'b0;
    pend[1] = 1'b1; cur[1] = 8'hC3; apply();
    drain("post_drop_drain");
    chk("err_sticky", err_o, 1);
    chk("post_drop_byte", m_last_byte, 8'hC3);

    // Asynchronous reset during CHECK.
    repeat (50) step();
    pend[0] = 1'b1; cur[0] = 8'h77; apply();
    cnt = 0;
    while (!(uart_we_o && uart_addr_o == 32'hC) && cnt < 60) begin step(); cnt++; end
    step();
    start = rdy_cnt[0];
    chk("pre_rst_check_ready", req_ready_o, 1);
    rst = 1'b0;
    #1;
    chk("arst_uart_req", uart_req_o, 0);
    chk("arst_we",       uart_we_o, 0);
    chk("arst_addr",     uart_addr_o, 0);
    chk("arst_data",     uart_data_o, 0);
    chk("arst_ready",    req_ready_o, 0);
    chk("arst_err",      err_o, 0);
    step();
    step();
    chk("arst_no_pulse", rdy_cnt[0] - start, 0);
    rst = 1'b1;
    #1;
    check_init("reinit");
    drain("reinit_drain");
    chk("reinit_byte", m_last_byte, 8'h77);

    chk("no_write_while_busy", viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
